seg_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the 8-digit seven-segment display peripheral at 0xFFFF_F000.
- Drives the active-low digit enable bus `led_en` that the display datapath decodes to select which digit pattern appears on `led_cx`.
- Configured by the CPU through one MMIO register at offset 0x004 (0xFFFF_F004).
- Provides per-digit masking, programmable dwell time, and a blanking gap between digits to suppress ghosting.

---
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 8-digit seven-segment display: walks the enabled digits,
// holds each for a programmable dwell and blanks between digits to avoid ghosting.
module seg_scan_ctrl #(
   parameter int                 DWELL_W   = 16,
   parameter logic [DWELL_W-1:0] DWELL_RST = 16'd50000,
   parameter int                 GAP_CYC   = 4,
   parameter logic [11:0]        CFG_ADDR  = 12'h004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] i_addr,
   input  logic        i_wen,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic [7:0]  o_led_en,
   output logic [2:0]  o_digit_sel,
   output logic        o_seg_blank,
   output logic        o_frame_tick
);

   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_GAP} state_t;

   localparam logic [DWELL_W-1:0] GAP_LOAD = DWELL_W'(GAP_CYC - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic [DWELL_W-1:0] r_dwell;
   logic [7:0]         r_mask;
   logic               r_scan_en;
   logic [7:0]         r_led_en;
   logic [7:0]         w_led_nxt;
   logic [2:0]         r_digit_sel;
   logic [2:0]         w_sel_nxt;
   logic               r_seg_blank;
   logic               w_blank_nxt;
   logic               r_frame_tick;
   logic               w_tick_nxt;
   logic               w_cfg_wr;
   logic [7:0]         w_mask_eff;
   logic [DWELL_W-1:0] w_dwell_load;
   logic               w_unused;

   function automatic logic [2:0] f_lowest(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Next enabled digit strictly after cur, wrapping; returns cur if it is the only one.
   function automatic logic [2:0] f_next(input logic [7:0] m, input logic [2:0] cur);
      logic [2:0] idx;
      logic [2:0] cand;
      logic       found;
      idx   = cur;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cand = cur + 3'(k);
         if (!found && m[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   assign w_cfg_wr     = i_wen && (i_addr == CFG_ADDR);
   assign w_mask_eff   = w_cfg_wr ? i_wdata[23:16] : r_mask;
   assign w_dwell_load = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
   assign w_unused     = &{1'b0, i_wdata[31:25]};

   assign o_rdata      = (i_addr == CFG_ADDR) ? {7'd0, r_scan_en, r_mask, r_dwell} : 32'd0;
   assign o_led_en     = r_led_en;
   assign o_digit_sel  = r_digit_sel;
   assign o_seg_blank  = r_seg_blank;
   assign o_frame_tick = r_frame_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dwell   <= DWELL_RST;
         r_mask    <= 8'hFF;
         r_scan_en <= 1'b1;
      end else if (w_cfg_wr) begin
         r_dwell   <= i_wdata[DWELL_W-1:0];
         r_mask    <= i_wdata[23:16];
         r_scan_en <= i_wdata[24];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_led_en     <= 8'hFF;
         r_digit_sel  <= 3'd0;
         r_seg_blank  <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_led_en     <= w_led_nxt;
         r_digit_sel  <= w_sel_nxt;
         r_seg_blank  <= w_blank_nxt;
         r_frame_tick <= w_tick_nxt;
      end
   end

   // Outputs are computed for the state being entered, so they line up with it after the edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_led_nxt   = r_led_en;
      w_sel_nxt   = r_digit_sel;
      w_blank_nxt = r_seg_blank;
      w_tick_nxt  = 1'b0;
      if (!r_scan_en || (r_mask == 8'd0)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_led_nxt   = 8'hFF;
         w_blank_nxt = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_DWELL;
               w_sel_nxt   = f_lowest(r_mask);
               w_led_nxt   = ~(8'd1 << w_sel_nxt);
               w_blank_nxt = 1'b0;
               w_tick_nxt  = 1'b1;
               w_cnt_nxt   = w_dwell_load;
            end
            S_DWELL: begin
               if (r_cnt == '0) begin
                  w_state_nxt = S_GAP;
                  w_cnt_nxt   = GAP_LOAD;
                  w_led_nxt   = 8'hFF;
                  w_blank_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - DWELL_W'(1);
               end
            end
            S_GAP: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - DWELL_W'(1);
               end else if (w_mask_eff == 8'd0) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_DWELL;
                  w_sel_nxt   = f_next(w_mask_eff, r_digit_sel);
                  w_led_nxt   = ~(8'd1 << w_sel_nxt);
                  w_blank_nxt = 1'b0;
                  w_tick_nxt  = (w_sel_nxt <= r_digit_sel);
                  w_cnt_nxt   = w_dwell_load;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_led_nxt   = 8'hFF;
               w_blank_nxt = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a scan-order model fills a queue of expected
// {led_en, digit_sel, seg_blank, frame_tick} words that are popped once per cycle.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr;
   logic        wen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  led_en;
   logic [2:0]  digit_sel;
   logic        seg_blank;
   logic        frame_tick;
   logic [12:0] obs;
   logic [12:0] expv;
   logic [12:0] sbq[$];
   int          total = 0;
   int          bad = 0;

   seg_scan_ctrl dut (
      .clk(clk), .rst(rst), .i_addr(addr), .i_wen(wen), .i_wdata(wdata),
      .o_rdata(rdata), .o_led_en(led_en), .o_digit_sel(digit_sel),
      .o_seg_blank(seg_blank), .o_frame_tick(frame_tick)
   );

   always #5 clk = ~clk;
   assign obs = {led_en, digit_sel, seg_blank, frame_tick};

   task automatic write_cfg(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0; addr = 12'h004;
   endtask

   task automatic stop_scan();
      write_cfg(12'h004, 32'h0000_0000);
      repeat (2) @(negedge clk);
   endtask

   // Expected per-cycle words for nvis digit visits starting from IDLE (GAP is 4 cycles).
   task automatic push_visits(input logic [7:0] m, input int dwell, input int nvis);
      int prev, d, de, cand;
      logic tick;
      de = (dwell == 0) ? 1 : dwell;
      prev = -1;
      d = 0;
      for (int v = 0; v < nvis; v++) begin
         if (v == 0) begin
            for (int i = 7; i >= 0; i--) if (m[i]) d = i;
         end else begin
            for (int k = 8; k >= 1; k--) begin
               cand = (prev + k) % 8;
               if (m[cand]) d = cand;
            end
         end
         tick = (v == 0) || (d <= prev);
         for (int c = 0; c < de; c++)
            sbq.push_back({~(8'd1 << d), 3'(d), 1'b0, (c == 0) ? tick : 1'b0});
         for (int c = 0; c < 4; c++)
            sbq.push_back({8'hFF, 3'(d), 1'b1, 1'b0});
         prev = d;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; wen = 1'b0; addr = 12'h004; wdata = 32'd0;
      repeat (2) @(negedge clk);
      total++;
      if (obs !== {8'hFF, 3'd0, 1'b1, 1'b0}) begin
         bad++; $display("[TB] FAIL reset_outputs: got %h want %h", obs, {8'hFF, 3'd0, 1'b1, 1'b0});
      end
      total++;
      if (rdata !== 32'h01FF_C350) begin
         bad++; $display("[TB] FAIL reset_cfg: got %h want %h", rdata, 32'h01FF_C350);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== {8'hFE, 3'd0, 1'b0, 1'b1}) begin
         bad++; $display("[TB] FAIL reset_first_digit: got %h want %h", obs, {8'hFE, 3'd0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_full_scan();
      stop_scan();
      write_cfg(12'h004, 32'h01FF_0003);
      push_visits(8'hFF, 3, 9);
      for (int i = 0; i < 63; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL full_scan[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
   endtask

   task automatic test_sparse_mask();
      stop_scan();
      write_cfg(12'h004, 32'h0185_0002);
      push_visits(8'h85, 2, 5);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL sparse_mask[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
   endtask

   task automatic test_single_digit();
      stop_scan();
      write_cfg(12'h004, 32'h0110_0003);
      push_visits(8'h10, 3, 3);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL single_digit[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
   endtask

   task automatic test_stop_restart();
      stop_scan();
      write_cfg(12'h004, 32'h01FF_0005);
      push_visits(8'hFF, 5, 4);
      // Digit 3 dwell occupies cycles 27..31; stop partway through it.
      for (int i = 0; i < 29; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL stop_pre[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
      write_cfg(12'h004, 32'h00FF_0005);
      @(negedge clk);
      total++;
      if (obs !== {8'hFF, 3'd3, 1'b1, 1'b0}) begin
         bad++; $display("[TB] FAIL stop_blank: got %h want %h", obs, {8'hFF, 3'd3, 1'b1, 1'b0});
      end
      repeat (5) @(negedge clk);
      total++;
      if (obs !== {8'hFF, 3'd3, 1'b1, 1'b0}) begin
         bad++; $display("[TB] FAIL stop_hold: got %h want %h", obs, {8'hFF, 3'd3, 1'b1, 1'b0});
      end
      write_cfg(12'h004, 32'h01FF_0005);
      push_visits(8'hFF, 5, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL restart[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
   endtask

   task automatic test_addr_decode();
      stop_scan();
      write_cfg(12'h004, 32'h00AA_0007);
      write_cfg(12'h000, 32'hFFFF_FFFF);
      write_cfg(12'h008, 32'hFFFF_FFFF);
      addr = 12'h004; #1;
      total++;
      if (rdata !== 32'h00AA_0007) begin
         bad++; $display("[TB] FAIL cfg_kept: got %h want %h", rdata, 32'h00AA_0007);
      end
      addr = 12'h008; #1;
      total++;
      if (rdata !== 32'd0) begin
         bad++; $display("[TB] FAIL rdata_other: got %h want %h", rdata, 32'd0);
      end
      addr = 12'h004;
      write_cfg(12'h004, 32'hFFFF_FFFF);
      #1;
      total++;
      if (rdata !== 32'h01FF_FFFF) begin
         bad++; $display("[TB] FAIL cfg_readback: got %h want %h", rdata, 32'h01FF_FFFF);
      end
   endtask

   task automatic test_dwell_zero();
      stop_scan();
      write_cfg(12'h004, 32'h0103_0000);
      push_visits(8'h03, 0, 3);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL dwell_zero[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
   endtask

   task automatic test_write_at_gap_exit();
      stop_scan();
      write_cfg(12'h004, 32'h0103_0002);
      push_visits(8'h03, 2, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL gap_exit_pre[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
      // This write lands on the GAP-exit edge, so the new mask steers the search to digit 2.
      write_cfg(12'h004, 32'h0104_0002);
      total++;
      if (obs !== {8'hFB, 3'd2, 1'b0, 1'b0}) begin
         bad++; $display("[TB] FAIL gap_exit_mask: got %h want %h", obs, {8'hFB, 3'd2, 1'b0, 1'b0});
      end
   endtask

   task automatic test_rst_mid_gap();
      stop_scan();
      write_cfg(12'h004, 32'h01FF_0002);
      push_visits(8'hFF, 2, 2);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); expv = sbq.pop_front(); total++;
         if (obs !== expv) begin bad++; $display("[TB] FAIL rst_pre[%0d]: got %h want %h", i, obs, expv); end
      end
      sbq.delete();
      #2 rst = 1'b1;
      #1;
      total++;
      if (obs !== {8'hFF, 3'd0, 1'b1, 1'b0}) begin
         bad++; $display("[TB] FAIL rst_async: got %h want %h", obs, {8'hFF, 3'd0, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== {8'hFE, 3'd0, 1'b0, 1'b1}) begin
         bad++; $display("[TB] FAIL rst_restart: got %h want %h", obs, {8'hFE, 3'd0, 1'b0, 1'b1});
      end
      total++;
      if (rdata !== 32'h01FF_C350) begin
         bad++; $display("[TB] FAIL rst_cfg: got %h want %h", rdata, 32'h01FF_C350);
      end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_sparse_mask();
      test_single_digit();
      test_stop_restart();
      test_addr_decode();
      test_dwell_zero();
      test_write_at_gap_exit();
      test_rst_mid_gap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
